wave_sequencer: RTL and testbench

Controller that sequences the wave-table/DAC datapath: it produces the wave-table read address and a per-sample load strobe at a programmable sample rate, runs for a programmed number of full wave cycles or continuously, and accepts register writes over a valid/ready configuration port. It sits between the (future) serial command decoder and the wave table feeding `dac_out`, replacing the free-running sample counter.

---
 rtl/wave_sequencer.sv | 172 +++++++++++++++++
 tb/tb_wave_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/wave_sequencer.sv
// rtl/wave_sequencer.sv - wave-table address/strobe sequencer with burst control
// Registers DIV/STEP/BURST over a valid/ready port; DIV/STEP writes in RUN are deferred to the next wrap.
module wave_sequencer #(
  parameter int ADDR_W = 11,
  parameter int DIV_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [1:0]        cfg_addr,
  input  logic [15:0]       cfg_data,
  output logic [ADDR_W-1:0] table_addr,
  output logic              sample_stb,
  output logic              busy,
  output logic              done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_n;

  logic [DIV_W-1:0]  div_reg, div_n, div_sh, div_sh_n, cnt, cnt_n;
  logic [ADDR_W-1:0] step_reg, step_n, step_sh, step_sh_n, phase_n;
  logic [CNT_W-1:0]  burst_reg, burst_n, wave_cnt, wave_n, wave_inc;
  logic              div_pend, div_pend_n, step_pend, step_pend_n;
  logic              stb_n, busy_n, done_n, ready_n;
  logic              wr, start, stop;
  logic [DIV_W-1:0]  wr_div;
  logic [ADDR_W:0]   sum;

  assign wr       = cfg_valid && cfg_ready;
  assign stop     = wr && (cfg_addr == 2'd3) && cfg_data[1];
  assign start    = wr && (cfg_addr == 2'd3) && cfg_data[0] && !cfg_data[1];
  assign wr_div   = (DIV_W'(cfg_data) == '0) ? DIV_W'(1) : DIV_W'(cfg_data);
  assign sum      = {1'b0, table_addr} + {1'b0, step_reg};
  assign wave_inc = (wave_cnt == '1) ? wave_cnt : wave_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n     = state;
    div_n       = div_reg;
    step_n      = step_reg;
    burst_n     = burst_reg;
    div_sh_n    = div_sh;
    step_sh_n   = step_sh;
    div_pend_n  = div_pend;
    step_pend_n = step_pend;
    cnt_n       = cnt;
    phase_n     = table_addr;
    wave_n      = wave_cnt;
    stb_n       = 1'b0;
    done_n      = 1'b0;

    if (wr) begin
      case (cfg_addr)
        2'd0: begin
          if (state == RUN) begin
            div_sh_n   = wr_div;
            div_pend_n = 1'b1;
          end else begin
            div_n = wr_div;
          end
        end
        2'd1: begin
          if (state == RUN) begin
            step_sh_n   = ADDR_W'(cfg_data);
            step_pend_n = 1'b1;
          end else begin
            step_n = ADDR_W'(cfg_data);
          end
        end
        2'd2:    burst_n = CNT_W'(cfg_data);
        default: ;
      endcase
    end

    case (state)
      IDLE: begin
        cnt_n   = '0;
        phase_n = '0;
        wave_n  = '0;
        if (start) begin
          state_n = RUN;
          stb_n   = (div_reg == DIV_W'(1));
        end
      end
      RUN: begin
        if (stop) begin
          state_n = IDLE;
          cnt_n   = '0;
          phase_n = '0;
          wave_n  = '0;
        end else if (start) begin
          cnt_n   = '0;
          phase_n = '0;
          wave_n  = '0;
          stb_n   = (div_reg == DIV_W'(1));
        end else begin
          cnt_n = (cnt >= div_reg - DIV_W'(1)) ? '0 : cnt + DIV_W'(1);
          if (sample_stb) begin
            phase_n = sum[ADDR_W-1:0];
            // Deferred DIV/STEP land on the same edge the phase wraps.
            if (sum[ADDR_W]) begin
              wave_n = wave_inc;
              if (div_pend) begin
                div_n      = div_sh;
                div_pend_n = 1'b0;
              end
              if (step_pend) begin
                step_n      = step_sh;
                step_pend_n = 1'b0;
              end
              if ((burst_n != '0) && (wave_inc >= burst_n)) begin
                state_n = IDLE;
                done_n  = 1'b1;
                cnt_n   = '0;
                phase_n = '0;
                wave_n  = '0;
              end
            end
          end
          if (state_n == RUN) stb_n = (cnt_n == div_n - DIV_W'(1));
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n  = (state_n == RUN);
    ready_n = !(div_pend_n || step_pend_n);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_reg    <= DIV_W'(16);
      step_reg   <= ADDR_W'(1);
      burst_reg  <= '0;
      div_sh     <= '0;
      step_sh    <= '0;
      div_pend   <= 1'b0;
      step_pend  <= 1'b0;
      cnt        <= '0;
      table_addr <= '0;
      wave_cnt   <= '0;
      sample_stb <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_ready  <= 1'b1;
    end else begin
      div_reg    <= div_n;
      step_reg   <= step_n;
      burst_reg  <= burst_n;
      div_sh     <= div_sh_n;
      step_sh    <= step_sh_n;
      div_pend   <= div_pend_n;
      step_pend  <= step_pend_n;
      cnt        <= cnt_n;
      table_addr <= phase_n;
      wave_cnt   <= wave_n;
      sample_stb <= stb_n;
      busy       <= busy_n;
      done       <= done_n;
      cfg_ready  <= ready_n;
    end
  end

endmodule

// File: tb/tb_wave_sequencer.sv
// tb/tb_wave_sequencer.sv - scoreboard bench for wave_sequencer
// Expected strobes (address, cycle) are queued when runs are started and checked as strobes appear.
module tb_wave_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic [10:0] table_addr;
  logic        sample_stb;
  logic        busy;
  logic        done;

  wave_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .table_addr (table_addr),
    .sample_stb (sample_stb),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [10:0] addr;
    int unsigned cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;
  int   done_seen   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_run(input int unsigned c0, input int unsigned div,
                          input int unsigned step, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.addr = 11'((i * step) % 2048);
      e.cyc  = c0 + i * div;
      sb.push_back(e);
    end
  endtask

  task automatic wait_q(input int left, input int budget);
    int n = 0;
    while (sb.size() > left && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("scoreboard_drain", 32'(sb.size()), 32'(left));
    if (sb.size() > left) sb.delete();
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [15:0] d, output int unsigned t);
    int n = 0;
    @(negedge clk);
    while (!cfg_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("cfg_ready_wait", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1;
    cfg_addr  = a;
    cfg_data  = d;
    @(posedge clk);
    #1;
    t = cyc;
    cfg_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && sample_stb) begin
      if (sb.size() == 0) begin
        check_eq("stb_unexpected", 32'(sample_stb), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("stb_addr", 32'(table_addr), 32'(mon_e.addr));
        check_eq("stb_cycle", cyc, mon_e.cyc);
      end
    end
    if (!reset && done) done_seen++;
  end

  initial begin
    int unsigned t, t2, tmp;
    reset     = 1'b1;
    cfg_valid = 1'b0;
    cfg_addr  = 2'd0;
    cfg_data  = 16'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 32'(cfg_ready), 32'd1);
    check_eq("rst_addr", 32'(table_addr), 32'd0);
    check_eq("rst_stb", 32'(sample_stb), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    reset = 1'b0;

    // Defaults, continuous: one full wave plus the wrap back to 0.
    cfg_write(2'd3, 16'h0001, t);
    push_run(t + 15, 16, 1, 2049);
    @(negedge clk);
    check_eq("cont_busy", 32'(busy), 32'd1);
    wait_q(0, 2048 * 16 + 100);
    check_eq("cont_no_done", 32'(done_seen), 32'd0);
    cfg_write(2'd3, 16'h0002, tmp);
    @(negedge clk);
    check_eq("cont_stop_busy", 32'(busy), 32'd0);

    // Burst of two waves at DIV=1, STEP=512.
    cfg_write(2'd0, 16'd1, tmp);
    cfg_write(2'd1, 16'd512, tmp);
    cfg_write(2'd2, 16'd2, tmp);
    cfg_write(2'd3, 16'h0001, t);
    push_run(t, 1, 512, 8);
    wait_q(0, 40);
    @(negedge clk);
    check_eq("burst_done", 32'(done), 32'd1);
    check_eq("burst_busy", 32'(busy), 32'd0);
    check_eq("burst_addr", 32'(table_addr), 32'd0);
    check_eq("burst_stb", 32'(sample_stb), 32'd0);
    @(negedge clk);
    #1;
    check_eq("burst_done_pulse", 32'(done), 32'd0);
    check_eq("burst_done_count", 32'(done_seen), 32'd1);

    // Shadowed STEP write mid-wave at DIV=4.
    cfg_write(2'd2, 16'd0, tmp);
    cfg_write(2'd0, 16'd4, tmp);
    cfg_write(2'd1, 16'd1, tmp);
    cfg_write(2'd3, 16'h0001, t);
    push_run(t + 3, 4, 1, 2048);
    repeat (40) @(negedge clk);
    cfg_write(2'd1, 16'd2, tmp);
    push_run(t + 3 + 4 * 2048, 4, 2, 3);
    @(negedge clk);
    check_eq("shadow_ready_low", 32'(cfg_ready), 32'd0);
    wait_q(3, 9000);
    check_eq("shadow_ready_at_wrap", 32'(cfg_ready), 32'd0);
    @(negedge clk);
    check_eq("shadow_ready_back", 32'(cfg_ready), 32'd1);
    check_eq("shadow_wrap_addr", 32'(table_addr), 32'd0);
    wait_q(0, 30);
    cfg_write(2'd3, 16'h0002, tmp);

    // STOP after the third strobe.
    cfg_write(2'd1, 16'd1, tmp);
    cfg_write(2'd3, 16'h0001, t);
    push_run(t + 3, 4, 1, 3);
    wait_q(0, 40);
    cfg_write(2'd3, 16'h0003, tmp);
    @(negedge clk);
    check_eq("stop_busy", 32'(busy), 32'd0);
    check_eq("stop_addr", 32'(table_addr), 32'd0);
    check_eq("stop_done", 32'(done), 32'd0);
    repeat (20) @(negedge clk);
    #1;
    check_eq("stop_no_done", 32'(done_seen), 32'd1);

    // DIV=0 stored as 1; START while running restarts at address 0.
    cfg_write(2'd0, 16'd0, tmp);
    cfg_write(2'd3, 16'h0001, t);
    push_run(t, 1, 1, 4);
    repeat (3) @(posedge clk);
    cfg_write(2'd3, 16'h0001, t2);
    check_eq("restart_edge", t2, t + 4);
    push_run(t2, 1, 1, 1);
    cfg_write(2'd3, 16'h0002, tmp);
    wait_q(0, 10);
    check_eq("restart_stop_busy", 32'(busy), 32'd0);

    // Reset mid-run, then defaults must be back.
    cfg_write(2'd0, 16'd5, tmp);
    cfg_write(2'd1, 16'd3, tmp);
    cfg_write(2'd3, 16'h0001, t);
    push_run(t + 4, 5, 3, 2);
    wait_q(0, 40);
    reset = 1'b1;
    @(negedge clk);
    check_eq("midrst_ready", 32'(cfg_ready), 32'd1);
    check_eq("midrst_addr", 32'(table_addr), 32'd0);
    check_eq("midrst_stb", 32'(sample_stb), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_done", 32'(done), 32'd0);
    reset = 1'b0;
    cfg_write(2'd3, 16'h0001, t);
    push_run(t + 15, 16, 1, 2);
    wait_q(0, 60);
    cfg_write(2'd3, 16'h0002, tmp);
    @(negedge clk);
    #1;
    check_eq("final_busy", 32'(busy), 32'd0);
    check_eq("final_done_count", 32'(done_seen), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
